// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register of the 5-stage RV32I core.
// Owns load-use hazard detection, EX bubble insertion and a bubble counter.
module id_ex_pipe_reg #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid_id,
  input  logic [XLEN-1:0]   i_pc_id,
  input  logic [XLEN-1:0]   i_rs1_data_id,
  input  logic [XLEN-1:0]   i_rs2_data_id,
  input  logic [XLEN-1:0]   i_immgen_id,
  input  logic [4:0]        i_rs1_addr_id,
  input  logic [4:0]        i_rs2_addr_id,
  input  logic              i_rs1_used_id,
  input  logic              i_rs2_used_id,
  input  logic [4:0]        i_rd_addr_id,
  input  logic              i_rd_wren_id,
  input  logic              i_mem_rden_id,
  input  logic [CTRL_W-1:0] i_ctrl_id,
  input  logic              i_flush_ex,
  input  logic              i_stall_mem,
  output logic              o_valid_ex,
  output logic [XLEN-1:0]   o_pc_ex,
  output logic [XLEN-1:0]   o_rs1_data_ex,
  output logic [XLEN-1:0]   o_rs2_data_ex,
  output logic [XLEN-1:0]   o_imm_ex,
  output logic [4:0]        o_rs1_addr_ex,
  output logic [4:0]        o_rs2_addr_ex,
  output logic [4:0]        o_rd_addr_ex,
  output logic              o_rd_wren_ex,
  output logic              o_mem_rden_ex,
  output logic [CTRL_W-1:0] o_ctrl_ex,
  output logic              o_stall_id,
  output logic [CNT_W-1:0]  o_bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic              rd_wren;
    logic              mem_rden;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_t;

  id_ex_t ex_q;
  id_ex_t ex_d;
  logic   hazard;
  logic   rs1_hit;
  logic   rs2_hit;
  logic   ld_in_ex;

  // Load-use detection against the load currently held in EX; x0 never hazards.
  always_comb begin
    ld_in_ex = ex_q.valid & ex_q.mem_rden & ex_q.rd_wren
             & (ex_q.rd_addr != 5'd0);
    rs1_hit  = i_rs1_used_id & (i_rs1_addr_id == ex_q.rd_addr);
    rs2_hit  = i_rs2_used_id & (i_rs2_addr_id == ex_q.rd_addr);
    hazard   = i_valid_id & ld_in_ex & (rs1_hit | rs2_hit);
  end

  assign o_stall_id = ~i_flush_ex & (i_stall_mem | hazard);

  // Next bundle on a plain load; side-effect bits are masked for dead slots.
  always_comb begin
    ex_d          = '0;
    ex_d.valid    = i_valid_id;
    ex_d.pc       = i_pc_id;
    ex_d.rs1_data = i_rs1_data_id;
    ex_d.rs2_data = i_rs2_data_id;
    ex_d.imm      = i_immgen_id;
    ex_d.rs1_addr = i_rs1_addr_id;
    ex_d.rs2_addr = i_rs2_addr_id;
    ex_d.rd_addr  = i_rd_addr_id;
    ex_d.rd_wren  = i_rd_wren_id & i_valid_id;
    ex_d.mem_rden = i_mem_rden_id & i_valid_id;
    ex_d.ctrl     = i_ctrl_id;
  end

  // EX register: flush beats memory stall, which beats load-use bubble.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ex_q         <= '0;
      o_bubble_cnt <= '0;
    end else if (i_flush_ex) begin
      ex_q <= '0;
    end else if (i_stall_mem) begin
      ex_q <= ex_q;
    end else if (hazard) begin
      ex_q <= '0;
      if (o_bubble_cnt != '1)
        o_bubble_cnt <= o_bubble_cnt + 1'b1;
    end else begin
      ex_q <= ex_d;
    end
  end

  assign o_valid_ex    = ex_q.valid;
  assign o_pc_ex       = ex_q.pc;
  assign o_rs1_data_ex = ex_q.rs1_data;
  assign o_rs2_data_ex = ex_q.rs2_data;
  assign o_imm_ex      = ex_q.imm;
  assign o_rs1_addr_ex = ex_q.rs1_addr;
  assign o_rs2_addr_ex = ex_q.rs2_addr;
  assign o_rd_addr_ex  = ex_q.rd_addr;
  assign o_rd_wren_ex  = ex_q.rd_wren;
  assign o_mem_rden_ex = ex_q.mem_rden;
  assign o_ctrl_ex     = ex_q.ctrl;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench for id_ex_pipe_reg with a queue of expected EX bundles.
// Counter width is reduced so saturation is reachable quickly.
module tb_id_ex_pipe_reg;

  localparam int CW = 4;

  logic        clk, rst;
  logic        valid_id;
  logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]  rs1_addr_id, rs2_addr_id, rd_addr_id;
  logic        rs1_used_id, rs2_used_id, rd_wren_id, mem_rden_id;
  logic [15:0] ctrl_id;
  logic        flush_ex, stall_mem;
  logic        valid_ex;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_addr_ex, rs2_addr_ex, rd_addr_ex;
  logic        rd_wren_ex, mem_rden_ex;
  logic [15:0] ctrl_ex;
  logic        stall_id;
  logic [CW-1:0] bubble_cnt;

  id_ex_pipe_reg #(.XLEN(32), .CTRL_W(16), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid_id(valid_id),
    .i_pc_id(pc_id), .i_rs1_data_id(rs1_data_id),
    .i_rs2_data_id(rs2_data_id), .i_immgen_id(imm_id),
    .i_rs1_addr_id(rs1_addr_id), .i_rs2_addr_id(rs2_addr_id),
    .i_rs1_used_id(rs1_used_id), .i_rs2_used_id(rs2_used_id),
    .i_rd_addr_id(rd_addr_id), .i_rd_wren_id(rd_wren_id),
    .i_mem_rden_id(mem_rden_id), .i_ctrl_id(ctrl_id),
    .i_flush_ex(flush_ex), .i_stall_mem(stall_mem),
    .o_valid_ex(valid_ex), .o_pc_ex(pc_ex),
    .o_rs1_data_ex(rs1_data_ex), .o_rs2_data_ex(rs2_data_ex),
    .o_imm_ex(imm_ex), .o_rs1_addr_ex(rs1_addr_ex),
    .o_rs2_addr_ex(rs2_addr_ex), .o_rd_addr_ex(rd_addr_ex),
    .o_rd_wren_ex(rd_wren_ex), .o_mem_rden_ex(mem_rden_ex),
    .o_ctrl_ex(ctrl_ex), .o_stall_id(stall_id),
    .o_bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        v;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  a1, a2, rd;
    logic        we, re;
    logic [15:0] ctrl;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   errors = 0;
  int   checks = 0;
  logic [CW-1:0] ecnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(logic v, logic [31:0] pc, logic [4:0] a1,
                       logic u1, logic [4:0] a2, logic u2,
                       logic [4:0] rd, logic we, logic re,
                       logic [31:0] imm, logic [15:0] ctrl);
    valid_id = v; pc_id = pc; imm_id = imm; ctrl_id = ctrl;
    rs1_addr_id = a1; rs1_used_id = u1;
    rs2_addr_id = a2; rs2_used_id = u2;
    rd_addr_id = rd; rd_wren_id = we; mem_rden_id = re;
    rs1_data_id = {16'hA1A1, pc[15:0]};
    rs2_data_id = {16'hB2B2, pc[15:0]};
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e = '{v:0, pc:0, r1:0, r2:0, imm:0, a1:0, a2:0, rd:0,
          we:0, re:0, ctrl:0, cnt:ecnt};
    return e;
  endfunction

  task automatic push_load();
    exp_t e;
    e = '{v:valid_id, pc:pc_id, r1:rs1_data_id, r2:rs2_data_id,
          imm:imm_id, a1:rs1_addr_id, a2:rs2_addr_id, rd:rd_addr_id,
          we:valid_id & rd_wren_id, re:valid_id & mem_rden_id,
          ctrl:ctrl_id, cnt:ecnt};
    q.push_back(e);
  endtask

  task automatic push_bubble(logic counted);
    if (counted && ecnt != '1) ecnt = ecnt + 1'b1;
    q.push_back(zero_exp());
  endtask

  task automatic cmp_ex(string tag, exp_t e);
    chk({tag, ".valid"}, 32'(valid_ex), 32'(e.v));
    chk({tag, ".pc"}, pc_ex, e.pc);
    chk({tag, ".rs1d"}, rs1_data_ex, e.r1);
    chk({tag, ".rs2d"}, rs2_data_ex, e.r2);
    chk({tag, ".imm"}, imm_ex, e.imm);
    chk({tag, ".rs1a"}, 32'(rs1_addr_ex), 32'(e.a1));
    chk({tag, ".rs2a"}, 32'(rs2_addr_ex), 32'(e.a2));
    chk({tag, ".rd"}, 32'(rd_addr_ex), 32'(e.rd));
    chk({tag, ".wren"}, 32'(rd_wren_ex), 32'(e.we));
    chk({tag, ".rden"}, 32'(mem_rden_ex), 32'(e.re));
    chk({tag, ".ctrl"}, 32'(ctrl_ex), 32'(e.ctrl));
    chk({tag, ".cnt"}, 32'(bubble_cnt), 32'(e.cnt));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      last = q.pop_front();
      cmp_ex(tag, last);
    end
  endtask

  task automatic chk_stall(string tag, logic exp);
    #1;
    chk(tag, 32'(stall_id), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; flush_ex = 1'b0; stall_mem = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    last = zero_exp();
    cmp_ex("reset", last);
    chk("reset.stall", 32'(stall_id), 32'h0);
    rst = 1'b0;

    // straight-line ADDI x2,x1,-2048
    drive(1, 32'h100, 1, 1, 0, 0, 2, 1, 0, 32'hFFFFF800, 16'h00A5);
    chk_stall("addi.stall", 1'b0);
    push_load();
    step("addi");

    // LOAD with dead ID slot masks side-effect bits
    drive(0, 32'h200, 3, 1, 4, 1, 9, 1, 1, 32'h55, 16'h1234);
    push_load();
    step("dead");

    // load-use: LW x5 then ADD x6,x5,x7
    drive(1, 32'h104, 1, 1, 0, 0, 5, 1, 1, 32'h10, 16'h0003);
    push_load();
    step("lw5");
    drive(1, 32'h108, 5, 1, 7, 1, 6, 1, 0, 32'h0, 16'h0011);
    chk_stall("lu.stall", 1'b1);
    push_bubble(1'b1);
    step("lu.bubble");
    chk_stall("lu.release", 1'b0);
    push_load();
    step("lu.add");

    // async reset between edges, counter included
    #2;
    rst = 1'b1;
    #1;
    ecnt = '0;
    last = zero_exp();
    cmp_ex("midrst", last);
    rst = 1'b0;

    // LW x0 then use x0: no stall
    drive(1, 32'h300, 1, 1, 0, 0, 0, 1, 1, 32'h4, 16'h0003);
    push_load();
    step("lw0");
    drive(1, 32'h304, 0, 1, 0, 1, 8, 1, 0, 32'h0, 16'h0011);
    chk_stall("x0.stall", 1'b0);
    push_load();
    step("usex0");

    // LW x5 then LUI x5 with unused source fields
    drive(1, 32'h308, 1, 1, 0, 0, 5, 1, 1, 32'h8, 16'h0003);
    push_load();
    step("lw5b");
    drive(1, 32'h30C, 5, 0, 5, 0, 5, 1, 0, 32'h12345000, 16'h0021);
    chk_stall("lui.stall", 1'b0);
    push_load();
    step("lui");

    // flush wins over load-use and is not counted
    drive(1, 32'h310, 1, 1, 0, 0, 5, 1, 1, 32'hC, 16'h0003);
    push_load();
    step("lw5c");
    drive(1, 32'h314, 2, 1, 5, 1, 6, 1, 0, 32'h0, 16'h0011);
    flush_ex = 1'b1;
    chk_stall("flush.stall", 1'b0);
    push_bubble(1'b0);
    step("flush");
    flush_ex = 1'b0;

    // memory stall holds EX for three cycles
    drive(1, 32'h400, 3, 1, 4, 1, 10, 1, 0, 32'h7F, 16'h0F0F);
    push_load();
    step("pre.hold");
    drive(1, 32'h404, 10, 1, 0, 0, 11, 1, 0, 32'h1, 16'h0101);
    stall_mem = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_stall($sformatf("hold%0d.stall", i), 1'b1);
      q.push_back(last);
      step($sformatf("hold%0d", i));
    end
    stall_mem = 1'b0;
    chk_stall("unhold.stall", 1'b0);
    push_load();
    step("unhold");

    // saturate the bubble counter with 2^CW+2 load-use events
    for (int n = 0; n < (1 << CW) + 2; n++) begin
      drive(1, 32'h500 + 32'(n * 8), 1, 1, 0, 0, 7, 1, 1, 32'h0, 16'h3);
      push_load();
      step($sformatf("sat.lw%0d", n));
      drive(1, 32'h504 + 32'(n * 8), 7, 1, 0, 0, 9, 1, 0, 32'h0, 16'h11);
      push_bubble(1'b1);
      step($sformatf("sat.bub%0d", n));
    end
    chk("sat.final", 32'(bubble_cnt), 32'((1 << CW) - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
